dot_prod_seq: RTL and testbench
===============================

# dot_prod_seq

Sequencer that computes one signed dot product of `len` terms by streaming operand pairs from a synchronous dual-word operand RAM into the downstream multiply-accumulator. It generates the accumulator's synchronous-load strobe and captures the final sum. It presents the result on a valid/ready port. It sits between the operand buffer (upstream) and the MAC (downstream), one job at a time.

## Interface
- `AW`, default 27: operand A width, signed.
- `BW`, default 18: operand B width, signed.
- `PW`, default 48: accumulator/result width, signed.
- `LW`, default 8: length/address width.
- `MAC_LAT`, default 3: cycles from a MAC operand cycle to that term appearing on `mac_p`.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: job request, sampled only in IDLE.
- `len` in LW: number of terms, sampled with `start`.
- `rd_en` out 1: operand RAM read enable, registered.
- `rd_addr` out LW: operand RAM address, registered.
- `rd_a` in AW: RAM word A, valid the cycle after `rd_en`.
- `rd_b` in BW: RAM word B, valid the cycle after `rd_en`.
- `mac_a` out AW: MAC operand A, registered.
- `mac_b` out BW: MAC operand B, registered.
- `mac_sload` out 1: MAC synchronous load, registered.
- `mac_p` in PW: MAC accumulator output.
- `res_valid` out 1: result valid.
- `res_data` out PW: result, stable while `res_valid`.
- `res_ready` in 1: result accepted when high with `res_valid`.
- `busy` out 1: high in every state except IDLE.

## Operation
- Reset values:
  - All outputs are 0.
  - State is IDLE, counters are 0.
- State machine IDLE → FETCH → DRAIN → HOLD → IDLE.
  - **IDLE**: on `start` with `len`≥1, latch `len` and go to FETCH. On `start` with `len`=0, go directly to HOLD with `res_data`=0 and no RAM reads.
  - **FETCH**: one read per cycle, `rd_addr`=0,1,…,len−1, `rd_en`=1. After address len−1, go to DRAIN.
  - **DRAIN**: wait MAC_LAT+2 cycles, then capture `mac_p` into `res_data` and go to HOLD.
  - **HOLD**: `res_valid`=1. On `res_ready`=1, clear `res_valid` and return to IDLE.
- Operand path:
  - `mac_a`/`mac_b` are `rd_a`/`rd_b` registered when the cycle carries a fetched term.
  - Otherwise they are forced to 0, so the MAC accumulates zeros during padding and the sum stays stable.
- MAC load contract:
  - `mac_sload` is a one-cycle pulse in the cycle after term 0 is on `mac_a`/`mac_b`.
  - This clears the accumulator so `mac_p` holds term 0 alone and sums onward.
- Arithmetic:
  - The sum is two's complement modulo 2^PW.
  - No saturation, no overflow flag.
- Boundary conditions:
  - `start` outside IDLE is ignored.
  - `res_ready` without `res_valid` has no effect.
  - `len`=2^LW−1 is legal.
  - `rst` mid-job returns to IDLE immediately with all outputs 0. Stale MAC contents are harmless because the next job's `mac_sload` clears them.

## Timing
Let cycle 0 be the cycle in which `start` is high in IDLE, and N = `len`.
- Cycles 1..N: `rd_en`=1, `rd_addr`=k−1.
- Cycles 2..N+1: RAM data valid.
- Cycles 3..N+2: `mac_a`/`mac_b` carry terms 0..N−1.
- Cycle 4: `mac_sload`=1, for any N≥1.
- Cycle N+5: `mac_p` holds the full sum (with MAC_LAT=3). It is captured at the end of that cycle.
- Cycle N+6 onward: `res_valid`=1 until the handshake.
  - If `res_ready` is high in cycle N+6, IDLE is re-entered in cycle N+7 and `start` is accepted there.
- For N=0: `res_valid`=1 in cycle 1.
- `busy` rises in cycle 1 and falls in the cycle after the handshake.

## Test plan
- **Basic 4-term job**: N=4, A={1,2,3,4}, B={5,6,7,8}, `res_ready` tied high. Required: `res_data`=70, `res_valid` in cycle 10 for exactly one cycle, `rd_addr` 0..3 in cycles 1..4, `mac_sload` only in cycle 4.
- **Single term and zero length**:
  - N=1 with A=−3, B=7 → `res_data`=−21 in cycle 7.
  - N=0 → `res_data`=0 in cycle 1 with `rd_en` never asserted.
- **Back-pressure**: N=2 with A={−1,−1}, B={1,1}; hold `res_ready` low 10 cycles and pulse `start` during HOLD. Required: `res_data`=−2 stable throughout, the extra `start` ignored, IDLE one cycle after `res_ready`.
- **Wrap-around**: N=16, all A=−2^26, all B=−2^17. Each product is 2^43 and the sum 2^47 wraps, so `res_data`=−2^47.
- **Reset mid-FETCH**: assert `rst` in cycle 3 of an N=8 job. Required:
  - All outputs 0 immediately.
  - A following N=2 job with A={10,20}, B={1,1} returns 30, proving the accumulator was cleared by `mac_sload`.
- **Back-to-back jobs**: start the next job in the cycle IDLE is re-entered. Required: correct independent sums with no carry-over from the previous job.

Source files
------------

// File: rtl/dot_prod_seq_if.sv
// Port bundle between the dot-product sequencer and its environment:
// job request, operand RAM read port, MAC operand/load port, result handshake.
interface dot_prod_seq_if #(
    parameter int AW = 27,
    parameter int BW = 18,
    parameter int PW = 48,
    parameter int LW = 8
);
    logic          start;
    logic [LW-1:0] len;
    logic          rd_en;
    logic [LW-1:0] rd_addr;
    logic [AW-1:0] rd_a;
    logic [BW-1:0] rd_b;
    logic [AW-1:0] mac_a;
    logic [BW-1:0] mac_b;
    logic          mac_sload;
    logic [PW-1:0] mac_p;
    logic          res_valid;
    logic [PW-1:0] res_data;
    logic          res_ready;
    logic          busy;

    // Environment side: issues jobs, owns the RAM and the MAC, consumes results.
    modport master (
        output start, len, rd_a, rd_b, mac_p, res_ready,
        input  rd_en, rd_addr, mac_a, mac_b, mac_sload, res_valid, res_data, busy
    );

    // Sequencer side.
    modport slave (
        input  start, len, rd_a, rd_b, mac_p, res_ready,
        output rd_en, rd_addr, mac_a, mac_b, mac_sload, res_valid, res_data, busy
    );
endinterface

// File: rtl/dot_prod_seq.sv
// Dot-product sequencer: streams len operand pairs from a synchronous RAM
// into an external MAC, pulses the MAC load one cycle after term 0, waits
// out the MAC pipeline and presents the captured sum on a valid/ready port.
module dot_prod_seq #(
    parameter int AW      = 27,
    parameter int BW      = 18,
    parameter int PW      = 48,
    parameter int LW      = 8,
    parameter int MAC_LAT = 3
) (
    input logic           clk,
    input logic           rst,
    dot_prod_seq_if.slave bus
);

    // Drain lasts MAC_LAT+2 cycles: one for the RAM-to-operand register,
    // one for the last term's operand cycle, MAC_LAT for the MAC pipeline.
    localparam int            DW         = $clog2(MAC_LAT + 2) + 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LAT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

    state_t        state;
    state_t        next_state;

    logic [LW-1:0] len_q;
    logic [LW-1:0] len_last;
    logic [DW-1:0] drain_cnt;

    logic          rd_en_q;
    logic [LW-1:0] rd_addr_q;
    logic          res_valid_q;
    logic          busy_q;
    logic [PW-1:0] res_data_q;

    logic          rd_en_nxt;
    logic [LW-1:0] rd_addr_nxt;
    logic          res_valid_nxt;
    logic          busy_nxt;

    logic          data_vld;
    logic          rd_first;
    logic          mac_first;
    logic          mac_sload_q;
    logic [AW-1:0] mac_a_q;
    logic [BW-1:0] mac_b_q;

    logic          job_zero;
    logic          drain_done;

    assign len_last   = len_q - LW'(1);
    assign job_zero   = (state == IDLE) && bus.start && (bus.len == '0);
    assign drain_done = (state == DRAIN) && (drain_cnt == DRAIN_LAST);

    // State register.
    // NOTE: every clocked process uses non-blocking assignments so all flops
    // sample the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic.
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (bus.start)              next_state = (bus.len == '0) ? HOLD : FETCH;
            FETCH: if (rd_addr_q == len_last)  next_state = DRAIN;
            DRAIN: if (drain_cnt == DRAIN_LAST) next_state = HOLD;
            HOLD:  if (bus.res_ready)          next_state = IDLE;
            default:                           next_state = IDLE;
        endcase
    end

    // Output decode: values the output registers take on the next edge.
    always_comb begin
        rd_en_nxt     = (next_state == FETCH);
        rd_addr_nxt   = '0;
        res_valid_nxt = (next_state == HOLD);
        busy_nxt      = (next_state != IDLE);
        if (state == FETCH && next_state == FETCH) rd_addr_nxt = rd_addr_q + LW'(1);
    end

    // Output registers, so every control output is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rd_en_q     <= rd_en_nxt;
            rd_addr_q   <= rd_addr_nxt;
            res_valid_q <= res_valid_nxt;
            busy_q      <= busy_nxt;
        end
    end

    // Job length latch and drain-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q     <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == IDLE && bus.start) len_q <= bus.len;
            drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
        end
    end

    // Operand path: register RAM data when it carries a term, zeros otherwise;
    // track term 0 down the pipe so the MAC load lands one cycle behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_vld    <= 1'b0;
            rd_first    <= 1'b0;
            mac_first   <= 1'b0;
            mac_sload_q <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
        end else begin
            data_vld    <= rd_en_q;
            rd_first    <= rd_en_q && (rd_addr_q == '0);
            mac_first   <= rd_first;
            mac_sload_q <= mac_first;
            mac_a_q     <= data_vld ? bus.rd_a : '0;
            mac_b_q     <= data_vld ? bus.rd_b : '0;
        end
    end

    // Result capture: the MAC sum at the end of drain, or zero for an empty job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             res_data_q <= '0;
        else if (job_zero)   res_data_q <= '0;
        else if (drain_done) res_data_q <= bus.mac_p;
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.mac_a     = mac_a_q;
    assign bus.mac_b     = mac_b_q;
    assign bus.mac_sload = mac_sload_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dot_prod_seq.sv
// Directed bench for dot_prod_seq with a registered-output RAM model and a
// three-stage MAC model (product, accumulator, output register).
module tb_dot_prod_seq;

    localparam int AW      = 27;
    localparam int BW      = 18;
    localparam int PW      = 48;
    localparam int LW      = 8;
    localparam int MAC_LAT = 3;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dot_prod_seq_if #(.AW(AW), .BW(BW), .PW(PW), .LW(LW)) bus ();

    dot_prod_seq #(.AW(AW), .BW(BW), .PW(PW), .LW(LW), .MAC_LAT(MAC_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Operand RAM model: data valid the cycle after rd_en.
    logic [AW-1:0] ram_a [256];
    logic [BW-1:0] ram_b [256];
    logic [AW-1:0] rd_a_q = '0;
    logic [BW-1:0] rd_b_q = '0;

    always @(posedge clk) begin
        if (bus.rd_en) begin
            rd_a_q <= ram_a[bus.rd_addr];
            rd_b_q <= ram_b[bus.rd_addr];
        end
    end
    assign bus.rd_a = rd_a_q;
    assign bus.rd_b = rd_b_q;

    // MAC model, latency 3; never reset, so stale sums survive a sequencer reset.
    logic signed [PW-1:0] prod_q = '0;
    logic signed [PW-1:0] acc_q  = '0;
    logic signed [PW-1:0] p_q    = '0;

    always @(posedge clk) begin
        prod_q <= PW'($signed(bus.mac_a)) * PW'($signed(bus.mac_b));
        acc_q  <= bus.mac_sload ? prod_q : acc_q + prod_q;
        p_q    <= acc_q;
    end
    assign bus.mac_p = p_q;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rd_en"},     longint'(bus.rd_en),     0);
        check({tag, " rd_addr"},   longint'(bus.rd_addr),   0);
        check({tag, " mac_a"},     longint'(bus.mac_a),     0);
        check({tag, " mac_b"},     longint'(bus.mac_b),     0);
        check({tag, " mac_sload"}, longint'(bus.mac_sload), 0);
        check({tag, " res_valid"}, longint'(bus.res_valid), 0);
        check({tag, " res_data"},  longint'(bus.res_data),  0);
        check({tag, " busy"},      longint'(bus.busy),      0);
    endtask

    // Called at the falling edge of the cycle that becomes cycle 0, with
    // res_ready high. Returns at the falling edge of the cycle IDLE is re-entered.
    task automatic run_job(input string tag, input int n, input longint exp_sum);
        int vc;
        vc = (n == 0) ? 1 : n + 6;
        bus.start = 1'b1;
        bus.len   = LW'(n);
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= vc + 1; c++) begin
            check($sformatf("%s rd_en@%0d", tag, c), longint'(bus.rd_en), longint'(c <= n));
            if (c <= n)
                check($sformatf("%s rd_addr@%0d", tag, c), longint'(bus.rd_addr), longint'(c - 1));
            check($sformatf("%s sload@%0d", tag, c), longint'(bus.mac_sload), longint'(n >= 1 && c == 4));
            check($sformatf("%s valid@%0d", tag, c), longint'(bus.res_valid), longint'(c == vc));
            check($sformatf("%s busy@%0d", tag, c), longint'(bus.busy), longint'(c <= vc));
            if (c == vc)
                check($sformatf("%s data", tag), $signed(bus.res_data), exp_sum);
            if (c <= vc) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_a[i] = '0;
            ram_b[i] = '0;
        end
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.res_ready = 1'b1;
        rst           = 1'b1;
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic 4-term job: 1*5 + 2*6 + 3*7 + 4*8 = 70.
        for (int i = 0; i < 4; i++) begin
            ram_a[i] = AW'(i + 1);
            ram_b[i] = BW'(i + 5);
        end
        run_job("basic", 4, 70);
        @(negedge clk);

        // Single term: -3 * 7 = -21.
        ram_a[0] = -27'sd3;
        ram_b[0] = 18'sd7;
        run_job("single", 1, -21);
        @(negedge clk);

        // Zero length: immediate zero result, no reads.
        run_job("zero", 0, 0);
        @(negedge clk);

        // Back-pressure: -1*1 + -1*1 = -2, held for 10 cycles, extra start ignored.
        ram_a[0] = -27'sd1;  ram_b[0] = 18'sd1;
        ram_a[1] = -27'sd1;  ram_b[1] = 18'sd1;
        bus.res_ready = 1'b0;
        bus.start     = 1'b1;
        bus.len       = LW'(2);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        for (int h = 0; h < 10; h++) begin
            if (h == 3) begin
                bus.start = 1'b1;
                bus.len   = LW'(5);
            end
            if (h == 4) bus.start = 1'b0;
            check($sformatf("bp valid@%0d", h), longint'(bus.res_valid), 1);
            check($sformatf("bp data@%0d", h),  $signed(bus.res_data), -2);
            check($sformatf("bp rd_en@%0d", h), longint'(bus.rd_en), 0);
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        check("bp valid at ready", longint'(bus.res_valid), 1);
        @(negedge clk);
        check("bp valid after", longint'(bus.res_valid), 0);
        check("bp busy after",  longint'(bus.busy), 0);
        @(negedge clk);
        check("bp no restart", longint'(bus.rd_en), 0);

        // Wrap-around: 16 * (-2^26 * -2^17) = 2^47, which wraps to -2^47.
        for (int i = 0; i < 16; i++) begin
            ram_a[i] = 27'h400_0000;
            ram_b[i] = 18'h2_0000;
        end
        run_job("wrap", 16, -(longint'(1) <<< 47));
        @(negedge clk);

        // Reset in cycle 3 of an 8-term job, while term 0 sits on mac_a.
        for (int i = 0; i < 8; i++) begin
            ram_a[i] = AW'(100 + i);
            ram_b[i] = BW'(3);
        end
        bus.start = 1'b1;
        bus.len   = LW'(8);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid mac_a before rst", longint'(bus.mac_a), 100);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ram_a[0] = AW'(10);  ram_b[0] = BW'(1);
        ram_a[1] = AW'(20);  ram_b[1] = BW'(1);
        run_job("after_rst", 2, 30);
        @(negedge clk);

        // Back-to-back: 1*4 + 2*5 + 3*6 = 32, then 7*-1 + 8*2 = 9.
        ram_a[0] = AW'(1);  ram_b[0] = BW'(4);
        ram_a[1] = AW'(2);  ram_b[1] = BW'(5);
        ram_a[2] = AW'(3);  ram_b[2] = BW'(6);
        run_job("b2b_1", 3, 32);
        ram_a[0] = AW'(7);  ram_b[0] = -18'sd1;
        ram_a[1] = AW'(8);  ram_b[1] = BW'(2);
        run_job("b2b_2", 2, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
